// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, assembles each 32-bit instruction from
// four little-endian byte reads and presents {pc, inst, valid} to IF/ID.
// A jump from EX aborts any fetch in progress and restarts at the target.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        jmp_in,
    input  logic [31:0] jmp_addr_in,
    input  logic        blk_in,
    input  logic        mem_stall_in,
    input  logic [7:0]  mem_din_in,
    output logic        mem_rd_out,
    output logic [31:0] mem_a_out,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_inst_out,
    output logic        rec_out
);

    typedef enum logic {
        FETCH   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     pc_q;
    logic [2:0]      req_cnt_q;
    logic [2:0]      rcv_cnt_q;
    logic            pend_q;
    logic [3:0][7:0] asm_q;
    logic [31:0]     a_last_q;

    logic            fetch_rd;
    logic            serviced;
    logic            last_byte;
    logic            consume;
    logic [31:0]     jmp_pc;

    assign fetch_rd  = (state_q == FETCH) && (req_cnt_q < 3'd4);
    assign serviced  = mem_rd_out && !mem_stall_in;
    assign last_byte = (state_q == FETCH) && pend_q && (rcv_cnt_q == 3'd3);
    assign consume   = (state_q == PRESENT) && !blk_in;
    assign jmp_pc    = {jmp_addr_in[31:2], 2'b00};

    // State register.
    always_ff @(posedge clk_in) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update together from pre-edge values, whatever the block order.
        if (!rst_in) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a jump always restarts fetching; otherwise the last byte
    // moves to PRESENT and consumption moves back to FETCH.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (jmp_in) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH:   if (last_byte) state_d = PRESENT;
                PRESENT: if (!blk_in)   state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Memory request outputs from registered state; the address holds its
    // last value whenever no read is being requested.
    always_comb begin
        mem_rd_out = 1'b0;
        mem_a_out  = 32'h0000_0000;
        if (rst_in) begin
            mem_rd_out = fetch_rd;
            mem_a_out  = fetch_rd ? (pc_q + {29'b0, req_cnt_q}) : a_last_q;
        end
    end

    // PC, request/capture counters and the read-in-flight flag.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pc_q      <= RESET_PC;
            req_cnt_q <= 3'd0;
            rcv_cnt_q <= 3'd0;
            pend_q    <= 1'b0;
            a_last_q  <= 32'h0000_0000;
        end else begin
            a_last_q <= mem_a_out;
            if (jmp_in) begin
                // Clearing pend drops the byte of any read serviced this cycle.
                pc_q      <= jmp_pc;
                req_cnt_q <= 3'd0;
                rcv_cnt_q <= 3'd0;
                pend_q    <= 1'b0;
            end else if (consume) begin
                pc_q      <= pc_q + 32'd4;
                req_cnt_q <= 3'd0;
                rcv_cnt_q <= 3'd0;
                pend_q    <= 1'b0;
            end else begin
                if (serviced) begin
                    req_cnt_q <= req_cnt_q + 3'd1;
                end
                pend_q <= serviced;
                if (pend_q) begin
                    rcv_cnt_q <= rcv_cnt_q + 3'd1;
                end
            end
        end
    end

    // Byte assembly buffer, written in little-endian order as bytes arrive.
    always_ff @(posedge clk_in) begin
        // NOTE: the buffer has no reset; every byte is rewritten before the
        // word is presented, so its power-up contents are never observed.
        if (rst_in && !jmp_in && pend_q) begin
            asm_q[rcv_cnt_q[1:0]] <= mem_din_in;
        end
    end

    // Presented instruction: loaded on the last byte, dropped on consume,
    // jump or reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rec_out     <= 1'b0;
            if_pc_out   <= 32'h0000_0000;
            if_inst_out <= 32'h0000_0000;
        end else if (jmp_in) begin
            rec_out <= 1'b0;
        end else if (last_byte) begin
            if_inst_out <= {mem_din_in, asm_q[2], asm_q[1], asm_q[0]};
            if_pc_out   <= pc_q;
            rec_out     <= 1'b1;
        end else if (consume) begin
            rec_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// stall/block/jump/reset traffic, checked every cycle against a
// transaction-level model of the fetch stage.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_in;
    logic        rst_in;
    logic        jmp_in;
    logic [31:0] jmp_addr_in;
    logic        blk_in;
    logic        mem_stall_in;
    logic [7:0]  mem_din_in;
    logic        mem_rd_out;
    logic [31:0] mem_a_out;
    logic [31:0] if_pc_out;
    logic [31:0] if_inst_out;
    logic        rec_out;

    int checks = 0;
    int errors = 0;

    // Model: PC of the instruction being fetched, reads serviced so far,
    // cycles since the fetch began, stalled request cycles, presenting flag.
    logic [31:0] m_pc;
    int          m_srv;
    int          m_age;
    int          m_stl;
    bit          m_present;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .jmp_in       (jmp_in),
        .jmp_addr_in  (jmp_addr_in),
        .blk_in       (blk_in),
        .mem_stall_in (mem_stall_in),
        .mem_din_in   (mem_din_in),
        .mem_rd_out   (mem_rd_out),
        .mem_a_out    (mem_a_out),
        .if_pc_out    (if_pc_out),
        .if_inst_out  (if_inst_out),
        .rec_out      (rec_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Memory contents: the test program at 0..3, a scrambled pattern elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] t;
        case (a)
            32'd0:   t = 8'h13;
            32'd1:   t = 8'h05;
            32'd2:   t = 8'h10;
            32'd3:   t = 8'h00;
            default: t = (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Byte-wide memory: data for a serviced read arrives the next cycle,
    // garbage otherwise so stale captures show up as wrong words.
    always @(posedge clk_in) begin
        if (mem_rd_out && !mem_stall_in) mem_din_in <= mem_byte(mem_a_out);
        else                             mem_din_in <= 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_start(input logic [31:0] pc);
        m_pc      = pc;
        m_srv     = 0;
        m_age     = 0;
        m_stl     = 0;
        m_present = 1'b0;
    endtask

    // One cycle: drive inputs, compare outputs with the model, then advance
    // the model across the coming clock edge.
    task automatic step(input bit rst, input bit blk, input bit stall,
                        input bit jmp, input logic [31:0] jaddr);
        @(negedge clk_in);
        rst_in       = rst;
        blk_in       = blk;
        mem_stall_in = stall;
        jmp_in       = jmp;
        jmp_addr_in  = jaddr;
        #1;
        check("rec", rec_out, m_present);
        if (m_present) begin
            check("pc", if_pc_out, m_pc);
            check("inst", if_inst_out, mem_word(m_pc));
        end
        if (!rst) begin
            check("rst_rd", mem_rd_out, 0);
            check("rst_a", mem_a_out, 0);
        end else if (!m_present && m_srv < 4) begin
            check("rd", mem_rd_out, 1);
            check("addr", mem_a_out, m_pc + 32'(m_srv));
        end else begin
            check("rd_idle", mem_rd_out, 0);
            check("addr_hold", mem_a_out, m_pc + 32'd3);
        end

        if (!rst) begin
            model_start(RESET_PC);
        end else if (jmp) begin
            model_start({jaddr[31:2], 2'b00});
        end else if (m_present) begin
            if (!blk) model_start(m_pc + 32'd4);
        end else begin
            if (m_srv < 4) begin
                if (stall) m_stl++;
                else       m_srv++;
            end
            m_age++;
            // Four reads plus one cycle for the last byte, plus one per stall.
            if (m_age == 5 + m_stl) m_present = 1'b1;
        end
    endtask

    initial begin
        rst_in       = 1'b0;
        jmp_in       = 1'b0;
        jmp_addr_in  = 32'h0;
        blk_in       = 1'b0;
        mem_stall_in = 1'b0;
        model_start(RESET_PC);

        // Reset, then first fetch of 0x00100513 from address 0.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, 0, 0);
            if (i <= 4) check("t1_addr", mem_a_out, 32'(i - 1));
            if (i == 1) begin
                check("t1_rst_pc", if_pc_out, 32'h0);
                check("t1_rst_inst", if_inst_out, 32'h0);
            end
        end
        // Cycles 6-8 blocked: outputs hold, no reads.
        for (int i = 6; i <= 8; i++) begin
            step(1, 1, 0, 0, 0);
            check("t2_rec", rec_out, 1);
            check("t2_inst", if_inst_out, 32'h0010_0513);
            check("t2_pc", if_pc_out, 32'h0);
            check("t2_rd", mem_rd_out, 0);
        end
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t2_next_addr", mem_a_out, 32'd4);
        check("t2_next_rec", rec_out, 0);
        for (int i = 11; i <= 15; i++) step(1, 0, 0, 0, 0);

        // Two stall cycles while address 2 is presented.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check("t3_addr_c3", mem_a_out, 32'd2);
        step(1, 0, 1, 0, 0);
        check("t3_addr_c4", mem_a_out, 32'd2);
        step(1, 0, 0, 0, 0);
        check("t3_addr_c5", mem_a_out, 32'd2);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t3_rec_c7", rec_out, 0);
        step(1, 0, 0, 0, 0);
        check("t3_rec_c8", rec_out, 1);
        check("t3_inst", if_inst_out, 32'h0010_0513);

        // Jump to 0x1003 while byte 1 of pc 0 is in flight.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h0000_1003);
        step(1, 0, 0, 0, 0);
        check("t4_addr", mem_a_out, 32'h0000_1000);
        check("t4_rec", rec_out, 0);
        for (int i = 4; i <= 7; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t4_rec_j6", rec_out, 1);
        check("t4_pc", if_pc_out, 32'h0000_1000);
        check("t4_inst", if_inst_out, mem_word(32'h0000_1000));

        // Jump in a consuming PRESENT cycle wins over pc+4.
        for (int i = 9; i <= 13; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h0000_2000);
        check("t5_pc", if_pc_out, 32'h0000_1004);
        step(1, 0, 0, 0, 0);
        check("t5_addr", mem_a_out, 32'h0000_2000);

        // Reset in the third cycle of a fetch.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t6_rst_rd", mem_rd_out, 0);
        step(1, 0, 0, 0, 0);
        check("t6_rec", rec_out, 0);
        check("t6_pc", if_pc_out, 32'h0);
        check("t6_inst", if_inst_out, 32'h0);
        check("t6_addr", mem_a_out, RESET_PC);
        for (int i = 2; i <= 5; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t6_rec_c6", rec_out, 1);
        check("t6_word", if_inst_out, 32'h0010_0513);

        // Address wrap: fetch at 0xFFFFFFFC, then pc+4 wraps to 0.
        step(1, 0, 0, 1, 32'hFFFF_FFFE);
        for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t7_pc", if_pc_out, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0);
        check("t7_wrap_addr", mem_a_out, 32'h0);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] ja;
            ja = $urandom;
            if ($urandom_range(0, 3) == 0) ja = 32'hFFFF_FFF0 | {28'h0, ja[3:0]};
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 31) == 0,
                 ja);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
